// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg
// ID-to-EXE pipeline register with load-use bubble insertion, busy hold and
// flush clear. The registered write fields feed the GPR bypass next cycle.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_ID_*                    instruction fields leaving ID
//   i_ID_data_related_confict load-use conflict from the GPR bypass
//   i_EXE_busy                multi-cycle EXE unit not done
//   i_flush                   redirect from EXE
//   o_EXE_*                   registered copies of the ID fields
//   o_ID_stall                combinational hold request to IF and IF/ID
//   o_bubble_cnt, o_hold_cnt  saturating event counters
//   o_err                     sticky double-bubble error
//
// state  | meaning
// RUN    | last cycle loaded ID fields or a flush bubble
// HOLD   | last cycle held EXE fields for a busy EXE unit
// BUBBLE | last cycle inserted a load-use bubble
//
// The state machine only tracks history for the double-bubble check; it never
// changes the datapath priority.
module id_exe_pipe_reg #(
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_ID_valid,
   input  logic [31:0]         i_ID_pc,
   input  logic [31:0]         i_ID_rdata1,
   input  logic [31:0]         i_ID_rdata2,
   input  logic [31:0]         i_ID_imm,
   input  logic [ALU_OP_W-1:0] i_ID_alu_op,
   input  logic                i_ID_we,
   input  logic [4:0]          i_ID_waddr,
   input  logic                i_ID_get_result_in_EXE,
   input  logic                i_ID_get_result_in_MEM,
   input  logic                i_ID_data_related_confict,
   input  logic                i_EXE_busy,
   input  logic                i_flush,
   output logic                o_EXE_valid,
   output logic [31:0]         o_EXE_pc,
   output logic [31:0]         o_EXE_rdata1,
   output logic [31:0]         o_EXE_rdata2,
   output logic [31:0]         o_EXE_imm,
   output logic [ALU_OP_W-1:0] o_EXE_alu_op,
   output logic                o_EXE_we,
   output logic [4:0]          o_EXE_waddr,
   output logic                o_EXE_get_result_in_EXE,
   output logic                o_EXE_get_result_in_MEM,
   output logic                o_ID_stall,
   output logic [CNT_W-1:0]    o_bubble_cnt,
   output logic [CNT_W-1:0]    o_hold_cnt,
   output logic                o_err
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_BUBBLE = 2'd2;

   logic                valid_q, valid_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         rdata1_q, rdata1_d;
   logic [31:0]         rdata2_q, rdata2_d;
   logic [31:0]         imm_q, imm_d;
   logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
   logic                we_q, we_d;
   logic [4:0]          waddr_q, waddr_d;
   logic                gr_exe_q, gr_exe_d;
   logic                gr_mem_q, gr_mem_d;
   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                err_q, err_d;

   logic conflict;
   logic load_bubble;
   logic load_id;

   assign conflict   = i_ID_data_related_confict & i_ID_valid;
   assign o_ID_stall = !i_flush & (i_EXE_busy | conflict);

   always_comb begin
      state_d      = state_q;
      bubble_cnt_d = bubble_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      err_d        = err_q;
      load_bubble  = 1'b0;
      load_id      = 1'b0;

      if (i_flush) begin
         load_bubble = 1'b1;
         state_d     = ST_RUN;
      end else if (i_EXE_busy) begin
         if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + CNT_W'(1);
         state_d = ST_HOLD;
      end else if (conflict) begin
         // After one bubble the load has moved to MEM; a second conflict
         // means the bypass is misreporting. The bubble still goes in.
         if (state_q == ST_BUBBLE) err_d = 1'b1;
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         load_bubble = 1'b1;
         state_d     = ST_BUBBLE;
      end else begin
         load_id     = i_ID_valid;
         load_bubble = !i_ID_valid;
         state_d     = ST_RUN;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      alu_op_d = alu_op_q;
      we_d     = we_q;
      waddr_d  = waddr_q;
      gr_exe_d = gr_exe_q;
      gr_mem_d = gr_mem_q;
      if (load_bubble) begin
         valid_d  = 1'b0;
         pc_d     = '0;
         rdata1_d = '0;
         rdata2_d = '0;
         imm_d    = '0;
         alu_op_d = '0;
         we_d     = 1'b0;
         waddr_d  = '0;
         gr_exe_d = 1'b1;
         gr_mem_d = 1'b0;
      end else if (load_id) begin
         valid_d  = 1'b1;
         pc_d     = i_ID_pc;
         rdata1_d = i_ID_rdata1;
         rdata2_d = i_ID_rdata2;
         imm_d    = i_ID_imm;
         alu_op_d = i_ID_alu_op;
         we_d     = i_ID_we;
         waddr_d  = i_ID_waddr;
         gr_exe_d = i_ID_get_result_in_EXE;
         gr_mem_d = i_ID_get_result_in_MEM;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         rdata1_q     <= '0;
         rdata2_q     <= '0;
         imm_q        <= '0;
         alu_op_q     <= '0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         gr_exe_q     <= 1'b1;
         gr_mem_q     <= 1'b0;
         state_q      <= ST_RUN;
         bubble_cnt_q <= '0;
         hold_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         rdata1_q     <= rdata1_d;
         rdata2_q     <= rdata2_d;
         imm_q        <= imm_d;
         alu_op_q     <= alu_op_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         gr_exe_q     <= gr_exe_d;
         gr_mem_q     <= gr_mem_d;
         state_q      <= state_d;
         bubble_cnt_q <= bubble_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         err_q        <= err_d;
      end
   end

   assign o_EXE_valid             = valid_q;
   assign o_EXE_pc                = pc_q;
   assign o_EXE_rdata1            = rdata1_q;
   assign o_EXE_rdata2            = rdata2_q;
   assign o_EXE_imm               = imm_q;
   assign o_EXE_alu_op            = alu_op_q;
   assign o_EXE_we                = we_q;
   assign o_EXE_waddr             = waddr_q;
   assign o_EXE_get_result_in_EXE = gr_exe_q;
   assign o_EXE_get_result_in_MEM = gr_mem_q;
   assign o_bubble_cnt            = bubble_cnt_q;
   assign o_hold_cnt              = hold_cnt_q;
   assign o_err                   = err_q;

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

ID-to-EXE pipeline register with integrated hazard sequencing for the 5-stage core. It captures the bypassed operands and control fields leaving ID and presents them to EXE. On a load-use conflict flagged by the GPR bypass it inserts a bubble. It holds while a multi-cycle EXE unit is busy and clears on flush. Its registered EXE-side write fields (`o_EXE_we/waddr/get_result_*`) are the fields the GPR bypass consumes on the following cycle.

## Interface
Parameters:
- `ALU_OP_W`, 5: width of the ALU opcode field.
- `CNT_W`, 16: width of the saturating performance counters.

Ports:
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_ID_valid`  in  1  ID holds a real instruction.
- `i_ID_pc`  in  32  PC of the ID instruction.
- `i_ID_rdata1`, `i_ID_rdata2`  in  32 each  bypassed operands from the GPR bypass.
- `i_ID_imm`  in  32  extended immediate.
- `i_ID_alu_op`  in  ALU_OP_W  ALU operation.
- `i_ID_we`  in  1  instruction writes a GPR.
- `i_ID_waddr`  in  5  destination GPR.
- `i_ID_get_result_in_EXE`, `i_ID_get_result_in_MEM`  in  1 each  result-ready stage flags.
- `i_ID_data_related_confict`  in  1  load-use conflict from the GPR bypass.
- `i_EXE_busy`  in  1  multi-cycle EXE unit (mul/div) not done.
- `i_flush`  in  1  redirect from EXE (branch/exception).
- `o_EXE_valid`, `o_EXE_pc`, `o_EXE_rdata1`, `o_EXE_rdata2`, `o_EXE_imm`, `o_EXE_alu_op`, `o_EXE_we`, `o_EXE_waddr`, `o_EXE_get_result_in_EXE`, `o_EXE_get_result_in_MEM`  out  registered copies of the ID fields, same widths.
- `o_ID_stall`  out  1  combinational; IF and IF/ID must hold this cycle.
- `o_bubble_cnt`  out  CNT_W  bubbles inserted, saturating.
- `o_hold_cnt`  out  CNT_W  busy-hold cycles, saturating.
- `o_err`  out  1  sticky protocol error.

## Operation
- Bubble value: `valid=0`, `we=0`, `waddr=0`, `get_result_in_EXE=1`, `get_result_in_MEM=0`, `pc/rdata/imm/alu_op=0`.
- Per-cycle priority, highest first:
  1. **reset:** load bubble into all EXE fields; counters=0; `o_err=0`; state RUN.
  2. **flush:** load bubble; state RUN.
  3. **busy:** hold all EXE fields; `hold_cnt` += 1; state HOLD.
  4. **conflict** (`i_ID_data_related_confict & i_ID_valid`): load bubble; `bubble_cnt` += 1; state BUBBLE.
  5. **advance:** load the ID fields. When `i_ID_valid=0`, load the bubble regardless of the other ID inputs. State RUN.
- `o_ID_stall = !i_flush & (i_EXE_busy | (i_ID_data_related_confict & i_ID_valid))`.
- State machine RUN/HOLD/BUBBLE is used for checking only and never alters datapath priority. HOLD→RUN occurs on the first cycle with busy low and no conflict.
- **Double bubble:** a conflict while in state BUBBLE, with no intervening flush or busy, sets `o_err`. After one bubble the producing load sits in MEM, so the conflict must drop. The bubble is still inserted.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Latency is 1 cycle from ID inputs to `o_EXE_*`.
- `o_ID_stall` is combinational in the same cycle. `o_EXE_*` are registered only.
- Reset is synchronous: `i_rst_n` low at an edge produces the bubble on the outputs after that edge, and counters and `o_err` read 0. Reset asserted during HOLD discards the held instruction.
- **Flush with busy, same cycle:** flush wins; the bubble is loaded and `hold_cnt` is not incremented.
- **Flush with conflict, same cycle:** flush wins; `bubble_cnt` is not incremented and `o_ID_stall=0`.
- **Busy with conflict, same cycle:** busy wins; fields are held and only `hold_cnt` increments.
- **Waddr 0:** an ID instruction with `we=1`, `waddr=0` is forwarded unchanged. The bypass itself ignores register 0.

## Test plan
- **Reset:** hold `i_rst_n=0` for 2 edges → `o_EXE_valid=0`, `o_EXE_waddr=0`, `o_EXE_get_result_in_EXE=1`, both counters 0, `o_err=0`.
- **Advance:** ID valid, pc=0x100, rdata1=0xDEADBEEF, waddr=8, we=1 → next cycle EXE shows the same values and `o_ID_stall=0`.
- **Load-use:** conflict=1 for one cycle → `o_ID_stall=1` that cycle, bubble in EXE next cycle, `bubble_cnt=1`. The same instruction advances on the following cycle once conflict=0.
- **Busy hold:** busy=1 for 3 cycles while a valid instruction (pc=0x200) is in EXE → EXE fields unchanged, `hold_cnt=3`, `o_ID_stall=1` throughout.
- **Priority:** flush with busy and conflict in the same cycle → bubble next cycle, `o_ID_stall=0`, no counter change. Then conflict on 2 consecutive cycles → `o_err=1`, and it stays 1 until reset.
- **Saturation:** with CNT_W=4, 20 conflict/clear pairs → `bubble_cnt=15`.
